// File: rtl/dma_top_module.sv
// dma_top_module: toy processor, 8-bit DMA controller, 256x8 memory and two I/O devices
// sharing one address/data bus; DMA takes the bus through HREQ/HACK and moves one word per clock.
module dma_top_module #(
  parameter logic [7:0] IO1_RD_ADDR = 8'd65,
  parameter logic [7:0] IO1_RD_CNT  = 8'd7,
  parameter logic [7:0] IO1_WR_ADDR = 8'd68,
  parameter logic [7:0] IO1_WR_CNT  = 8'd8,
  parameter logic [7:0] IO2_RD_ADDR = 8'd100,
  parameter logic [7:0] IO2_RD_CNT  = 8'd4,
  parameter logic [7:0] IO2_WR_ADDR = 8'd120,
  parameter logic [7:0] IO2_WR_CNT  = 8'd4,
  parameter logic [7:0] M2M_CNT     = 8'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode_processor,
  input  logic [1:0] mode_io,
  input  logic [1:0] mode_io2,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [7:0] C,
  output logic [7:0] AB,
  output logic [7:0] DB,
  output logic [7:0] word_count,
  output logic [7:0] cnt_reg,
  output logic [7:0] src_reg,
  output logic [7:0] dest_reg,
  output logic [7:0] data_reg,
  output logic [7:0] data,
  output logic [7:0] address_sent_to_io,
  output logic       read_io,
  output logic       read_memory,
  output logic       Enable_memory,
  output logic       Enable_IO1,
  output logic       Enable_IO2,
  output logic       mem_op,
  output logic       DREQ1,
  output logic       DACK1,
  output logic       DREQ2,
  output logic       DACK2,
  output logic       HREQ,
  output logic       HACK,
  output logic       MemToMem,
  output logic       dma,
  output logic       cs
);
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_PROG = 3'd2, S_XFER = 3'd3, S_DONE = 3'd4;
  logic [2:0] state, mp_q;
  logic [1:0] ch, io1_q, io2_q;
  logic       io1_idle_q, io2_idle_q, mp_m2m_q, wr1, wr2, phase;
  logic [7:0] mem [256];
  logic       rise1, rise2, rise_m, clr1, clr2, clr_m, busy, step, to_done, is_m2m, cur_wr;
  logic       io_rd, io_wr, m_rd, m_wr, proc_ld, proc_st, we;
  logic [7:0] rd_src, io_val, alu, wa, wd, ld_cnt, ld_src, ld_dest;

  assign B       = 8'd20;
  assign rise1   = !io1_q[1] && io1_idle_q;
  assign rise2   = !io2_q[1] && io2_idle_q;
  assign rise_m  = mp_q == 3'b100 && !mp_m2m_q;
  assign busy    = state == S_PROG || state == S_XFER;
  assign step    = busy && cnt_reg != 8'd0;
  assign to_done = busy && cnt_reg == 8'd0;
  assign clr1    = to_done && ch == 2'd0;
  assign clr2    = to_done && ch == 2'd1;
  assign clr_m   = to_done && ch == 2'd2;
  assign is_m2m  = ch == 2'd2;
  assign cur_wr  = ch == 2'd0 ? wr1 : wr2;
  assign io_rd   = step && !is_m2m && !cur_wr;
  assign io_wr   = step && !is_m2m && cur_wr;
  assign m_rd    = step && is_m2m && !phase;
  assign m_wr    = step && is_m2m && phase;
  // storage holds value^address so a zero-initialised array reads back as mem[i]=i
  assign rd_src  = mem[src_reg] ^ src_reg;
  assign io_val  = (ch == 2'd0 ? 8'hA0 : 8'hB0) + word_count - cnt_reg;
  assign alu     = mode_processor[1:0] == 2'd0 ? A + B : mode_processor[1:0] == 2'd1 ? A - B :
                   mode_processor[0] ? A | B : A & B;
  assign proc_ld = !HACK && mode_processor == 3'b101;
  assign proc_st = !HACK && mode_processor == 3'b110;
  assign we      = io_wr || m_wr || proc_st;
  assign wa      = (io_wr || m_wr) ? dest_reg : B;
  assign wd      = io_wr ? io_val : m_wr ? data_reg : C;
  assign ld_cnt  = is_m2m ? M2M_CNT : ch == 2'd0 ? (wr1 ? IO1_WR_CNT : IO1_RD_CNT) : (wr2 ? IO2_WR_CNT : IO2_RD_CNT);
  assign ld_src  = is_m2m ? A : ch == 2'd0 ? IO1_RD_ADDR : IO2_RD_ADDR;
  assign ld_dest = is_m2m ? B : ch == 2'd0 ? IO1_WR_ADDR : IO2_WR_ADDR;

  always_ff @(posedge clk)
    if (we) mem[wa] <= wd ^ wa;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      A    <= 8'd10;
      C    <= '0;
      HACK <= 1'b0;
    end else begin
      HACK <= !to_done && (HACK || (HREQ && mode_processor != 3'b101 && mode_processor != 3'b110));
      if (!HACK && !mode_processor[2]) C <= alu;
      if (proc_ld) A <= mem[B] ^ B;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      io1_q      <= 2'b11;
      io2_q      <= 2'b11;
      io1_idle_q <= 1'b1;
      io2_idle_q <= 1'b1;
      mp_q       <= 3'b111;
      mp_m2m_q   <= 1'b0;
      DREQ1      <= 1'b0;
      DREQ2      <= 1'b0;
      MemToMem   <= 1'b0;
      wr1        <= 1'b0;
      wr2        <= 1'b0;
    end else begin
      io1_q      <= mode_io;
      io2_q      <= mode_io2;
      io1_idle_q <= io1_q[1];
      io2_idle_q <= io2_q[1];
      mp_q       <= mode_processor;
      mp_m2m_q   <= mp_q == 3'b100;
      DREQ1      <= (DREQ1 && !clr1) || rise1;
      DREQ2      <= (DREQ2 && !clr2) || rise2;
      MemToMem   <= (MemToMem && !clr_m) || rise_m;
      if (rise1 && !(DREQ1 && !clr1)) wr1 <= io1_q[0];
      if (rise2 && !(DREQ2 && !clr2)) wr2 <= io2_q[0];
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      ch <= '0;
      phase <= 1'b0;
      {HREQ, cs, dma, DACK1, DACK2} <= '0;
      {word_count, cnt_reg, src_reg, dest_reg, data_reg, data, address_sent_to_io, AB, DB} <= '0;
      {read_io, read_memory, Enable_memory, Enable_IO1, Enable_IO2, mem_op} <= '0;
    end else begin
      cs <= 1'b0;
      case (state)
        S_IDLE: if (DREQ1 || DREQ2 || MemToMem) begin
          state <= S_REQ;
          HREQ  <= 1'b1;
          ch    <= DREQ1 ? 2'd0 : DREQ2 ? 2'd1 : 2'd2;
        end
        S_REQ: if (HACK) begin
          state      <= S_PROG;
          {cs, dma}  <= 2'b11;
          DACK1      <= ch == 2'd0;
          DACK2      <= ch == 2'd1;
          phase      <= 1'b0;
          word_count <= ld_cnt;
          cnt_reg    <= ld_cnt;
          src_reg    <= ld_src;
          dest_reg   <= ld_dest;
        end
        S_PROG, S_XFER: if (to_done) begin
          state <= S_DONE;
          {HREQ, dma, DACK1, DACK2} <= '0;
        end else state <= S_XFER;
        default: state <= S_IDLE;
      endcase
      if (io_rd || m_rd) src_reg <= src_reg + 8'd1;
      if (io_wr || m_wr) dest_reg <= dest_reg + 8'd1;
      if (io_rd || io_wr || m_wr) cnt_reg <= cnt_reg - 8'd1;
      if (step && is_m2m) phase <= !phase;
      if (io_rd) data <= rd_src;
      if (m_rd) data_reg <= rd_src;
      if (io_rd || io_wr) address_sent_to_io <= io_rd ? src_reg : dest_reg;
      AB            <= (io_rd || m_rd) ? src_reg : (io_wr || m_wr) ? dest_reg : 8'd0;
      DB            <= (io_rd || m_rd) ? rd_src : io_wr ? io_val : m_wr ? data_reg : 8'd0;
      read_memory   <= io_rd || m_rd;
      read_io       <= io_wr;
      Enable_memory <= step;
      Enable_IO1    <= (io_rd || io_wr) && ch == 2'd0;
      Enable_IO2    <= (io_rd || io_wr) && ch == 2'd1;
      mem_op        <= step || proc_ld || proc_st;
    end
endmodule

// File: tb/tb_dma_top_module.sv
// tb_dma_top_module: scoreboard bench; a bus-level model predicts every DMA word and processor result.
module tb_dma_top_module;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] mode_processor = 3'b111;
  logic [1:0] mode_io = 2'b11, mode_io2 = 2'b11;
  logic [7:0] A, B, C, AB, DB, word_count, cnt_reg, src_reg, dest_reg, data_reg, data, address_sent_to_io;
  logic read_io, read_memory, Enable_memory, Enable_IO1, Enable_IO2, mem_op;
  logic DREQ1, DACK1, DREQ2, DACK2, HREQ, HACK, MemToMem, dma, cs;

  typedef struct packed {logic [7:0] ab; logic [7:0] db; logic rio; logic rmem; logic e1; logic e2;} exp_t;
  exp_t sb[$];
  exp_t mon_got, mon_exp;
  logic [7:0] mem_m [256];
  logic [7:0] A_m, C_m;
  int checks = 0, errors = 0;
  int em_cnt, last_d1, first_d2, m2m_seen;

  always #5 clk = ~clk;

  dma_top_module dut (
    .clk(clk), .rst_n(rst_n), .mode_processor(mode_processor), .mode_io(mode_io), .mode_io2(mode_io2),
    .A(A), .B(B), .C(C), .AB(AB), .DB(DB), .word_count(word_count), .cnt_reg(cnt_reg),
    .src_reg(src_reg), .dest_reg(dest_reg), .data_reg(data_reg), .data(data),
    .address_sent_to_io(address_sent_to_io), .read_io(read_io), .read_memory(read_memory),
    .Enable_memory(Enable_memory), .Enable_IO1(Enable_IO1), .Enable_IO2(Enable_IO2), .mem_op(mem_op),
    .DREQ1(DREQ1), .DACK1(DACK1), .DREQ2(DREQ2), .DACK2(DACK2), .HREQ(HREQ), .HACK(HACK),
    .MemToMem(MemToMem), .dma(dma), .cs(cs)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [7:0] ab, input logic [7:0] db, input logic rio, input logic rmem,
                              input logic e1, input logic e2);
    exp_t e;
    e.ab = ab; e.db = db; e.rio = rio; e.rmem = rmem; e.e1 = e1; e.e2 = e2;
    return e;
  endfunction

  function automatic int io_cnt(input int ch, input bit wr);
    return ch == 1 ? (wr ? 8 : 7) : 4;
  endfunction

  task automatic push_io(input int ch, input bit wr);
    logic [7:0] st, a, v;
    st = ch == 1 ? (wr ? 8'd68 : 8'd65) : (wr ? 8'd120 : 8'd100);
    for (int k = 0; k < io_cnt(ch, wr); k++) begin
      a = st + 8'(k);
      if (wr) begin
        v = (ch == 1 ? 8'hA0 : 8'hB0) + 8'(k);
        mem_m[a] = v;
        sb.push_back(mk(a, v, 1'b1, 1'b0, ch == 1, ch == 2));
      end else sb.push_back(mk(a, mem_m[a], 1'b0, 1'b1, ch == 1, ch == 2));
    end
  endtask

  task automatic push_m2m(input logic [7:0] s, input logic [7:0] d);
    logic [7:0] v;
    for (int k = 0; k < 4; k++) begin
      v = mem_m[8'(s + 8'(k))];
      sb.push_back(mk(s + 8'(k), v, 1'b0, 1'b1, 1'b0, 1'b0));
      sb.push_back(mk(d + 8'(k), v, 1'b0, 1'b0, 1'b0, 1'b0));
      mem_m[8'(d + 8'(k))] = v;
    end
  endtask

  task automatic wait_idle(input string nm, input int rel, input logic [2:0] pm);
    int n;
    em_cnt = 0; last_d1 = -1; first_d2 = -1; m2m_seen = 0;
    for (n = 0; n < 300; n++) begin
      if (n == rel) begin
        mode_io = 2'b11;
        mode_io2 = 2'b11;
        mode_processor = pm;
      end
      tick();
      em_cnt += int'(Enable_memory);
      if (DACK1) last_d1 = n;
      if (DACK2 && first_d2 < 0) first_d2 = n;
      if (MemToMem) m2m_seen = 1;
      if (n >= 3 && !(DREQ1 | DREQ2 | MemToMem | HREQ | HACK | dma)) break;
    end
    chk({nm, "_timeout"}, int'(n < 300), 1);
    tick();
    chk({nm, "_drained"}, sb.size(), 0);
  endtask

  function automatic logic [7:0] alu_m(input int o, input logic [7:0] a, input logic [7:0] b);
    return o == 0 ? a + b : o == 1 ? a - b : o == 2 ? a & b : a | b;
  endfunction

  always @(negedge clk)
    if (rst_n && Enable_memory) begin
      checks++;
      mon_got = {AB, DB, read_io, read_memory, Enable_IO1, Enable_IO2};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got bus word %h expected none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL sb_word: got %h expected %h", mon_got, mon_exp);
        end
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 8'(i);
    A_m = 8'd10; C_m = 8'd0;
    repeat (2) tick();
    chk("rst_A", A, 10); chk("rst_B", B, 20); chk("rst_C", C, 0);
    chk("rst_bus", {AB, DB}, 0); chk("rst_wc", word_count, 0); chk("rst_cnt", cnt_reg, 0);
    chk("rst_regs", {src_reg, dest_reg, data_reg, data, address_sent_to_io} == '0, 1);
    chk("rst_flags", {DREQ1, DACK1, DREQ2, DACK2, HREQ, HACK, MemToMem, dma, cs, read_io, read_memory,
                      Enable_memory, Enable_IO1, Enable_IO2, mem_op}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // IO1 read with edge-by-edge handshake timing
    mode_io = 2'b00;
    push_io(1, 0);
    for (int e = 0; e < 14; e++) begin
      tick();
      chk("t_dreq1", DREQ1, int'(e >= 1 && e <= 11));
      chk("t_hreq", HREQ, int'(e >= 2 && e <= 11));
      chk("t_hack", HACK, int'(e >= 3 && e <= 11));
      chk("t_dack1", DACK1, int'(e >= 4 && e <= 11));
      chk("t_cs", cs, int'(e == 4));
      if (e >= 4 && e <= 11) chk("t_cnt", cnt_reg, e == 4 ? 7 : 11 - e);
      if (e >= 5 && e <= 11) begin
        chk("t_data", data, e + 60);
        chk("t_ab", AB, e + 60);
      end
      if (e == 12) chk("t_ab_idle", AB, 0);
      if (e == 5) mode_io = 2'b11;
    end
    chk("t_wc", word_count, 7);
    wait_idle("io1_rd", 0, 3'b111);

    mode_io = 2'b01;
    push_io(1, 1);
    wait_idle("io1_wr", 5, 3'b111);
    chk("io1_wr_wc", word_count, 8); chk("io1_wr_cnt", cnt_reg, 0);

    // simultaneous requests: IO1 served before IO2
    mode_io = 2'b00; mode_io2 = 2'b00;
    push_io(1, 0); push_io(2, 0);
    wait_idle("both", 4, 3'b111);
    chk("both_order", int'(first_d2 > last_d1 && last_d1 >= 0), 1);
    chk("both_data", data, 103);

    // reset in the middle of a block
    mode_io = 2'b00;
    push_io(1, 0);
    repeat (8) tick();
    chk("mid_dack1", DACK1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hs", {DREQ1, DACK1, HREQ, HACK, dma, cs}, 0);
    chk("arst_bus", {AB, DB}, 0);
    sb.delete();
    mode_io = 2'b11;
    A_m = 8'd10; C_m = 8'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    mode_io = 2'b00;
    push_io(1, 0);
    wait_idle("restart", 3, 3'b111);
    chk("restart_wc", word_count, 7);

    // processor bus ops hold off the grant; registers freeze under HACK
    mode_processor = 3'b000;
    tick();
    C_m = alu_m(0, A_m, 8'd20);
    chk("alu_add", C, C_m);
    mode_processor = 3'b101;
    mode_io2 = 2'b00;
    push_io(2, 0);
    repeat (6) tick();
    A_m = mem_m[20];
    chk("hold_hack", HACK, 0); chk("hold_hreq", HREQ, 1); chk("hold_A", A, A_m);
    mode_processor = 3'b111;
    tick();
    chk("grant_hack", HACK, 1);
    mode_processor = 3'b001;
    repeat (2) tick();
    chk("frozen_C", C, C_m); chk("frozen_A", A, A_m);
    wait_idle("hack", 0, 3'b001);
    C_m = alu_m(1, A_m, 8'd20);
    chk("after_C", C, C_m);
    mode_processor = 3'b111;

    // mem-to-mem from A=10 to B=20
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    A_m = 8'd10; C_m = 8'd0;
    repeat (2) tick();
    mode_processor = 3'b100;
    push_m2m(A_m, 8'd20);
    wait_idle("m2m", 2, 3'b111);
    chk("m2m_seen", m2m_seen, 1); chk("m2m_xfer", em_cnt, 8); chk("m2m_wc", word_count, 4);
    mode_processor = 3'b101;
    tick();
    mode_processor = 3'b111;
    A_m = mem_m[20];
    chk("m2m_load", A, A_m);

    for (int it = 0; it < 40; it++) begin
      int op, o;
      op = int'($urandom_range(0, 7));
      if (op < 4) begin
        if (op < 2) mode_io = {1'b0, op[0]};
        else mode_io2 = {1'b0, op[0]};
        push_io(op < 2 ? 1 : 2, op[0]);
        wait_idle("rnd_io", int'($urandom_range(1, 6)), 3'b111);
        chk("rnd_io_wc", word_count, io_cnt(op < 2 ? 1 : 2, op[0]));
      end else if (op == 4) begin
        mode_processor = 3'b100;
        push_m2m(A_m, 8'd20);
        wait_idle("rnd_m2m", int'($urandom_range(1, 4)), 3'b111);
        chk("rnd_m2m_xfer", em_cnt, 8);
      end else if (op == 5) begin
        o = int'($urandom_range(0, 3));
        mode_processor = 3'(o);
        tick();
        mode_processor = 3'b111;
        C_m = alu_m(o, A_m, 8'd20);
        chk("rnd_alu", C, C_m);
      end else if (op == 6) begin
        mode_processor = 3'b101;
        tick();
        mode_processor = 3'b111;
        A_m = mem_m[20];
        chk("rnd_load", A, A_m);
      end else begin
        mode_processor = 3'b110;
        tick();
        mode_processor = 3'b111;
        mem_m[20] = C_m;
        chk("rnd_store_memop", mem_op, 1);
      end
    end
    mode_processor = 3'b101;
    tick();
    mode_processor = 3'b111;
    chk("final_load", A, mem_m[20]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_top_module.md
# dma_top_module

Self-contained DMA subsystem top level: a toy processor with registers A/B/C, an 8-bit DMA controller, a 256x8 memory and two I/O devices sharing one 8-bit address bus (AB) and data bus (DB). I/O devices request block transfers through DREQ/DACK. The DMA controller takes the bus from the processor through HREQ/HACK and moves one word per clock. All internal state and the handshake are visible on ports for bench observation.

## Interface
- Parameters:
- IO1_RD_ADDR, 65, IO1 memory->IO start address; IO1_RD_CNT, 7, word count.
- IO1_WR_ADDR, 68, IO1 IO->memory start address; IO1_WR_CNT, 8, word count.
- IO2_RD_ADDR, 100 / IO2_RD_CNT, 4; IO2_WR_ADDR, 120 / IO2_WR_CNT, 4.
- M2M_CNT, 4, memory-to-memory block length.
- Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode_processor  in  3  processor op: 000 add, 001 sub, 010 and, 011 or, 100 mem-to-mem request, 101 load A<=mem[B], 110 store mem[B]<=C, 111 idle.
- mode_io, mode_io2  in  2 each  IO1/IO2 request: 00 read block from memory, 01 write block to memory, 10/11 idle.
- A, B, C  out  8  processor registers (reset 10, 20, 0).
- AB, DB  out  8  address/data bus (0 when idle).
- word_count  out  8  block length of current/last transfer; cnt_reg out 8 remaining words.
- src_reg, dest_reg, data_reg  out  8  DMA source, destination, temp data.
- data  out  8  last byte received by an I/O device; address_sent_to_io out 8 memory address of current IO word.
- read_io, read_memory, Enable_memory, Enable_IO1, Enable_IO2, mem_op  out  1  bus strobes.
- DREQ1, DACK1, DREQ2, DACK2, HREQ, HACK, MemToMem, dma, cs  out  1  handshake/status.

## Operation
- Requests are edge-triggered: IO request latched when mode_io leaves idle (10/11) to 00/01; mem-to-mem latched when mode_processor enters 100. Pending latch raises DREQ1/DREQ2 (MemToMem for m2m) and holds until DONE. Later mode changes do not abort a started block.
- Priority when several pending: IO1 > IO2 > mem-to-mem.
- DMA FSM: IDLE -> REQ (HREQ=1) -> wait HACK -> PROG (cs=1, DACKn=1, load src/dest/word_count/cnt_reg) -> XFER -> DONE (drop DREQ/DACK/HREQ/dma) -> IDLE.
- Processor grants HACK at the first edge with HREQ=1 and mode_processor not 101/110; while HACK=1 processor registers freeze. HACK drops in DONE.
- IO read (00): src=start addr; each XFER cycle AB=src, read_memory=1, Enable_memory=1, Enable_IOn=1, DB=mem[src], data<=DB; src++, cnt_reg--.
- IO write (01): dest=start addr; IO drives DB=0xA0+k (IO1) / 0xB0+k (IO2), k=0..n-1, read_io=1, mem[dest]<=DB; dest++, cnt_reg--.
- Mem-to-mem: src=A, dest=B, count M2M_CNT; 2 cycles/word (read into data_reg, then write).
- dma=1 from PROG through last XFER; mem_op=1 in any cycle touching memory (DMA or processor 101/110).
- ALU ops 000-011 write C mod 256; 101/110 use B as address.
- Memory initialised mem[i]=i at time zero, not cleared by reset. Addresses wrap 255->0.

## Timing
- Reset: all outputs 0 except A=10, B=20; FSM IDLE; pending latches cleared. Reset mid-block aborts immediately; memory keeps written words.
- Request applied before edge 0: DREQ at edge 1, HREQ edge 2, HACK edge 3 (if processor not busy), PROG edge 4, first word edge 5, word n at edge 4+n, DONE the following edge, IDLE next.
- Processor in 101/110 holds off HACK; the grant follows the first non-bus cycle.
- cnt_reg reaches 0 on the last word; count 0 goes PROG->DONE directly.

## Test plan
- mode_processor=111, mode_io 11->00 held 6 cycles then 11 -> word_count=7, data sequence 65..71, cnt_reg 7->0, AB 65..71, DACK1 high 8 cycles.
- mode_io 11->01 held 5 cycles then 11 -> mem[68..75]=0xA0..0xA7, read_io=1 during XFER, word_count=8.
- mode_io and mode_io2 both 00 same edge -> IO1 block first, then IO2 block (data 100..103), DACK2 only after DONE of IO1.
- mode_processor=000 then 101 during HREQ -> C=30, HACK delayed until mode leaves 101, A frozen while HACK=1.
- mode_processor=100 with A=10,B=20 -> MemToMem=1, mem[20..23]=10..13, 8 XFER cycles.
- rst_n low mid-block -> all handshakes 0 asynchronously, new request restarts cleanly.
